preact_accumulator: RTL

Pipelined dot-product accumulator that produces the pre-activation operand for the SiLU activation stage. Consumes LEN signed fixed-point activation/weight pairs over a valid/ready stream, accumulates the aligned products in a guard-extended register, then narrows the sum back to the shared IL.FL format. Presents one result per vector to the downstream SiLU input over a valid/ready handshake.

---
 rtl/preact_accumulator_if.sv | 31 +++
 rtl/preact_accumulator.sv | 130 +++++++++++++
 2 files changed

// File: rtl/preact_accumulator_if.sv
// rtl/preact_accumulator_if.sv - operand/result stream bundle for preact_accumulator
// master drives pairs and accepts results; slave is the accumulator.
interface preact_accumulator_if #(
    parameter int IL  = 4,
    parameter int FL  = 16,
    parameter int LEN = 16
);
    localparam int W  = IL + FL;
    localparam int CW = $clog2(LEN);

    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  w;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          ovf;
    logic [CW-1:0] beat_cnt;

    modport master (
        output clr, in_valid, a, w, out_ready,
        input  in_ready, out_valid, out_data, ovf, beat_cnt
    );

    modport slave (
        input  clr, in_valid, a, w, out_ready,
        output in_ready, out_valid, out_data, ovf, beat_cnt
    );
endinterface

// File: rtl/preact_accumulator.sv
// rtl/preact_accumulator.sv - LEN-term QIL.FL dot product feeding the SiLU stage
// MAC_SAT_EN: saturate the narrowed result instead of wrapping it.
module preact_accumulator #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int LEN   = 16,
    parameter int GUARD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    preact_accumulator_if.slave  bus
);
    localparam int W  = IL + FL;
    localparam int AW = W + GUARD;
    localparam int PW = 2 * W;
    localparam int CW = $clog2(LEN);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic signed [AW-1:0]  r_acc;
    logic signed [AW-1:0]  w_acc_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [W-1:0]          r_out_data;
    logic [W-1:0]          w_out_data_nxt;
    logic                  r_ovf;
    logic                  w_ovf_nxt;
    logic                  r_out_valid;
    logic                  w_out_valid_nxt;

    logic signed [PW-1:0]  w_prod;
    logic signed [AW-1:0]  w_term;
    logic signed [AW-1:0]  w_sum;
    logic                  w_in_range;
    logic [W-1:0]          w_narrow;
    logic                  w_in_ready;
    logic                  w_beat;
    logic                  w_last;

    // Arithmetic shift floors toward -inf; the cast keeps the sign while resizing.
    assign w_prod = $signed(bus.a) * $signed(bus.w);
    assign w_term = AW'(w_prod >>> FL);
    assign w_sum  = r_acc + w_term;

    // Fits QIL.FL only when every bit from the result sign upward agrees.
    assign w_in_range = (&w_sum[AW-1:W-1]) | ~(|w_sum[AW-1:W-1]);

`ifdef MAC_SAT_EN
    always_comb begin
        w_narrow = w_sum[W-1:0];
        if (!w_in_range) begin
            w_narrow = w_sum[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    assign w_narrow = w_sum[W-1:0];
`endif

    assign w_in_ready = (r_state == ST_ACCUM) & ~bus.clr;
    assign w_beat     = bus.in_valid & w_in_ready;
    assign w_last     = (r_cnt == CW'(LEN - 1));

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_out_data_nxt  = r_out_data;
        w_ovf_nxt       = r_ovf;
        w_out_valid_nxt = r_out_valid;
        case (r_state)
            ST_ACCUM: begin
                if (bus.clr) begin
                    w_acc_nxt = '0;
                    w_cnt_nxt = '0;
                end else if (w_beat) begin
                    if (w_last) begin
                        w_out_data_nxt  = w_narrow;
                        w_ovf_nxt       = ~w_in_range;
                        w_out_valid_nxt = 1'b1;
                        w_acc_nxt       = '0;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = ST_HOLD;
                    end else begin
                        w_acc_nxt = w_sum;
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            ST_HOLD: begin
                // Held result survives clr; only the downstream handshake releases it.
                if (bus.out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_state_nxt     = ST_ACCUM;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_data  <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out_data  <= w_out_data_nxt;
            r_ovf       <= w_ovf_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.ovf       = r_ovf;
    assign bus.beat_cnt  = r_cnt;
endmodule
